// File: rtl/fetch_pc.sv
// fetch_pc: program-counter / fetch sequencing stage.
// Tracks IDLE/RUN/HALT, steps the PC, takes absolute bne jumps through a
// software-loaded branch-target table, and reports pc_valid/done.
// Optional build macro FETCH_BRANCH_CNT_EN adds a saturating taken_cnt port.
module fetch_pc #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned LUT_W      = 5,
  parameter int unsigned START_ADDR = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_en,
  input  logic             zero_i,
  input  logic [LUT_W-1:0] lut_idx,
  input  logic             lut_wr_en,
  input  logic [LUT_W-1:0] lut_wr_idx,
  input  logic [PC_W-1:0]  lut_wr_data,
  output logic [PC_W-1:0]  pc_o,
  output logic             pc_valid,
  output logic             done
`ifdef FETCH_BRANCH_CNT_EN
  ,
  output logic [15:0]      taken_cnt
`endif
);

  localparam int unsigned    LUT_DEPTH = 1 << LUT_W;
  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] lut [LUT_DEPTH];
  logic [PC_W-1:0] target;
  logic            taken;
  logic            run_go;

  // Branch target is a combinational table read; bne is taken when ALU flag is set
  always_comb begin
    target = lut[lut_idx];
    taken  = branch_en & zero_i;
    run_go = (state == RUN) & ~stall & ~halt_req;
  end

  // Sequencer: state, PC and the registered pc_valid/done decodes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc_o     <= START_PC;
      pc_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            pc_o     <= START_PC;
            pc_valid <= 1'b1;
            done     <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (halt_req) begin
              state    <= HALT;
              pc_valid <= 1'b0;
              done     <= 1'b1;
            end else if (taken) begin
              pc_o <= target;
            end else begin
              pc_o <= pc_o + 1'b1;
            end
          end
        end
        HALT: begin
          if (start) begin
            state    <= RUN;
            pc_o     <= START_PC;
            pc_valid <= 1'b1;
            done     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          pc_o     <= START_PC;
          pc_valid <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Target table: synchronous write in any state; same-cycle reads see the old entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
        lut[i] <= '0;
      end
    end else if (lut_wr_en) begin
      lut[lut_wr_idx] <= lut_wr_data;
    end
  end

`ifdef FETCH_BRANCH_CNT_EN
  // Taken-branch counter: saturates, cleared whenever execution (re)starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt <= '0;
    end else if (start && (state != RUN)) begin
      taken_cnt <= '0;
    end else if (run_go && taken && (taken_cnt != '1)) begin
      taken_cnt <= taken_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: scoreboard bench for fetch_pc. A behavioural model computes the
// expected PC/flags when stimulus is driven; a monitor compares after each edge.
// A second instance built with PC_W=4 covers the narrow-width wrap and reset abort.
module tb_fetch_pc;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       reset2_n = 1'b0;
  logic       start = 1'b0, stall = 1'b0, halt_req = 1'b0;
  logic       branch_en = 1'b0, zero_i = 1'b0, lut_wr_en = 1'b0;
  logic [4:0] lut_idx = '0, lut_wr_idx = '0;
  logic [9:0] lut_wr_data = '0;
  logic [9:0] pc_o;
  logic       pc_valid, done;
  logic [3:0] pc2_o;
  logic       pc2_valid, done2;
`ifdef FETCH_BRANCH_CNT_EN
  logic [15:0] taken_cnt, taken_cnt2;
`endif

  always #5 clk = ~clk;

  fetch_pc #(.PC_W(10), .LUT_W(5), .START_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
    .halt_req(halt_req), .branch_en(branch_en), .zero_i(zero_i),
    .lut_idx(lut_idx), .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx),
    .lut_wr_data(lut_wr_data), .pc_o(pc_o), .pc_valid(pc_valid), .done(done)
`ifdef FETCH_BRANCH_CNT_EN
    , .taken_cnt(taken_cnt)
`endif
  );

  fetch_pc #(.PC_W(4), .LUT_W(5), .START_ADDR(0)) dut4 (
    .clk(clk), .reset_n(reset2_n), .start(start), .stall(stall),
    .halt_req(halt_req), .branch_en(branch_en), .zero_i(zero_i),
    .lut_idx(lut_idx), .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx),
    .lut_wr_data(lut_wr_data[3:0]), .pc_o(pc2_o), .pc_valid(pc2_valid), .done(done2)
`ifdef FETCH_BRANCH_CNT_EN
    , .taken_cnt(taken_cnt2)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  typedef struct { bit sel; int pc; bit valid; bit done; int cnt; } exp_t;
  exp_t q[$];
  exp_t e;
  int   m_state;   // 0 idle, 1 run, 2 halt
  int   m_pc, m_cnt, m_mask;
  int   m_tbl [32];
  bit   m_sel;

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_cnt = 0;
    for (int i = 0; i < 32; i++) m_tbl[i] = 0;
  endtask

  task automatic drive(input bit st, input bit sl, input bit h, input bit b,
                       input bit z, input int idx, input bit we, input int wi,
                       input int wd);
    exp_t x;
    @(negedge clk);
    start = st; stall = sl; halt_req = h; branch_en = b; zero_i = z;
    lut_idx = 5'(idx); lut_wr_en = we; lut_wr_idx = 5'(wi); lut_wr_data = 10'(wd);
    case (m_state)
      0: if (st) begin m_state = 1; m_pc = 0; m_cnt = 0; end
      1: if (!sl) begin
           if (h) m_state = 2;
           else if (b && z) begin
             m_pc = m_tbl[idx];
             if (m_cnt < 16'hFFFF) m_cnt++;
           end else m_pc = (m_pc + 1) & m_mask;
         end
      default: if (st) begin m_state = 1; m_pc = 0; m_cnt = 0; end
    endcase
    if (we) m_tbl[wi] = wd & m_mask;
    x.sel = m_sel; x.pc = m_pc; x.valid = (m_state == 1);
    x.done = (m_state == 2); x.cnt = m_cnt;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare one expected record after every rising edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!e.sel) begin
        check("pc", int'(pc_o), e.pc);
        check("pc_valid", int'(pc_valid), int'(e.valid));
        check("done", int'(done), int'(e.done));
`ifdef FETCH_BRANCH_CNT_EN
        check("taken_cnt", int'(taken_cnt), e.cnt);
`endif
      end else begin
        check("pc4", int'(pc2_o), e.pc);
        check("pc4_valid", int'(pc2_valid), int'(e.valid));
        check("done4", int'(done2), int'(e.done));
      end
    end
  end

  initial begin
    // ---- main instance, PC_W=10 ----
    m_sel = 0; m_mask = 10'h3FF; model_reset();
    #12 reset_n = 1'b1;
    check("rst_pc", int'(pc_o), 0);
    check("rst_valid", int'(pc_valid), 0);
    check("rst_done", int'(done), 0);
    idle(2);
    drive(0, 0, 1, 1, 1, 3, 1, 3, 10'h120);      // IDLE ignores control, table write works
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);            // start -> pc 0
    idle(5);                                     // 1..5
    idle(2);                                     // 6,7
    drive(0, 0, 0, 1, 1, 3, 1, 4, 7);            // taken -> 0x120, table[4]=7
    drive(0, 0, 0, 1, 1, 4, 0, 0, 0);            // taken -> 7
    drive(0, 0, 0, 1, 0, 3, 0, 0, 0);            // not taken -> 8
    drive(0, 0, 0, 1, 1, 5, 1, 5, 10'h55);       // same-cycle write: old entry 0
    drive(0, 0, 0, 1, 1, 5, 0, 0, 0);            // new entry 0x55
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);            // start in RUN ignored
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);            // halt
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);            // restart -> 0
    idle(4);                                     // pc 4
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 1, 1, 3, 0, 0, 0); // stalled
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);            // halt at 4
    drive(0, 1, 1, 1, 1, 3, 0, 0, 0);            // HALT ignores everything
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);            // start with stall still restarts
    idle(9);                                     // pc 9
    drive(0, 0, 1, 1, 1, 3, 0, 0, 0);            // halt beats branch
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);            // restart
    drive(0, 0, 0, 1, 1, 3, 1, 6, 10'h3FE);      // counter: taken 1
    drive(0, 0, 0, 1, 1, 3, 0, 0, 0);            // taken 2
    drive(0, 0, 0, 1, 0, 3, 0, 0, 0);            // not taken
    drive(0, 0, 0, 1, 1, 6, 0, 0, 0);            // taken 3 -> 0x3FE
    idle(2);                                     // 0x3FF, wrap to 0
`ifdef FETCH_BRANCH_CNT_EN
    for (int i = 0; i < 70000; i++) drive(0, 0, 0, 1, 1, 3, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);            // start clears counter
`endif
    idle(1);
    @(posedge clk); #2;

    // ---- narrow instance, PC_W=4 ----
    m_sel = 1; m_mask = 4'hF; model_reset();
    reset2_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 1, 4'hE);         // table[1]=E
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 1, 0, 0, 0);            // -> E
    idle(3);                                     // F, 0, 1
    @(posedge clk); #2;
    reset2_n = 1'b0;                             // async abort mid-cycle
    #1;
    check("rst4_pc", int'(pc2_o), 0);
    check("rst4_valid", int'(pc2_valid), 0);
    check("rst4_done", int'(done2), 0);
    model_reset();
    @(negedge clk); reset2_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 1, 1, 1, 0, 0, 0);            // cleared table -> 0
    idle(1);

    @(posedge clk); #2;
    check("scoreboard_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
